// File: rtl/alu_pipe.sv
// alu_pipe: pipelined ALU with valid/ready handshakes on both sides.
// Stage 1 computes result and flags. Stages 2..STAGES only delay them.
// One global stall signal freezes every stage register when the output is full
// and the consumer is not ready.
// Optional feature: define ALU_PIPE_MAC_EN to build the multiply-accumulate
// unit that handles mode 3'b111. Without it, mode 3'b111 is reported as illegal.
module alu_pipe #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] val1,
  input  logic [WIDTH-1:0] val2,
  input  logic [2:0]       mode,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic             acc_clr,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             ovf,
  output logic             zero,
  output logic             err,
  output logic             valid_o,
  input  logic             ready_i
);

  // Shift amount width. A WIDTH of at least 2 keeps this at 1 bit or more.
  localparam int SHW = $clog2(WIDTH);
  // Packed stage payload: {result, carry, ovf, zero, err}.
  localparam int DW  = WIDTH + 4;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SHL = 3'b101,
    OP_MUL = 3'b110,
    OP_MAC = 3'b111
  } op_t;

  // Computes every operation except the accumulator path. Mode 3'b111 reports
  // as illegal here, and the MAC build overrides that result afterwards.
  function automatic logic [DW-1:0] alu_calc(
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b,
    input logic [2:0]       op
  );
    logic [WIDTH:0]   wide;
    logic [WIDTH-1:0] r;
    logic             c;
    logic             o;
    logic             e;
    wide = {(WIDTH+1){1'b0}};
    r    = {WIDTH{1'b0}};
    c    = 1'b0;
    o    = 1'b0;
    e    = 1'b0;
    case (op_t'(op))
      OP_ADD: begin
        wide = {1'b0, a} + {1'b0, b};
        r    = wide[WIDTH-1:0];
        c    = wide[WIDTH];
        // The sum overflows when both operands have the same sign and the
        // result has a different sign.
        o    = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        wide = {1'b0, a} - {1'b0, b};
        r    = wide[WIDTH-1:0];
        // The extra top bit is set exactly when val1 < val2 as unsigned values.
        c    = wide[WIDTH];
        // The difference overflows when the operand signs differ and the
        // result sign differs from the minuend.
        o    = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_SHL:  r = a << b[SHW-1:0];
      OP_MUL:  r = a * b;
      OP_MAC:  e = 1'b1;
      default: e = 1'b1;
    endcase
    return {r, c, o, (r == {WIDTH{1'b0}}), e};
  endfunction

  logic [DW-1:0]    calc_s;
  logic [DW-1:0]    alu_s;
  logic             accept_s;
  logic             advance_s;
  logic [DW-1:0]    data_r [STAGES];
  logic [STAGES-1:0] vld_r;

  // The global stall depends only on the output stage and the consumer.
  // An item leaves the output stage in the same cycle that a new one enters.
  assign advance_s = ready_i | ~vld_r[STAGES-1];
  assign ready_o   = advance_s;
  assign accept_s  = valid_i & advance_s;

  assign alu_s = alu_calc(val1, val2, mode);

`ifdef ALU_PIPE_MAC_EN
  logic [WIDTH-1:0] acc_r;
  logic [WIDTH-1:0] prod_s;
  logic [WIDTH-1:0] acc_next_s;

  // Product and next accumulator value. acc_clr restarts the sum from the
  // current product.
  always_comb begin
    prod_s     = val1 * val2;
    acc_next_s = {WIDTH{1'b0}};
    if (acc_clr) begin
      acc_next_s = prod_s;
    end else begin
      acc_next_s = acc_r + prod_s;
    end
  end

  // The accumulator changes only on an accepted item.
  // A non-MAC item clears it only when acc_clr is set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_r <= {WIDTH{1'b0}};
    end else if (accept_s) begin
      if (mode == OP_MAC) begin
        acc_r <= acc_next_s;
      end else if (acc_clr) begin
        acc_r <= {WIDTH{1'b0}};
      end else begin
        acc_r <= acc_r;
      end
    end
  end

  // A MAC item returns the updated accumulator with carry and ovf cleared.
  always_comb begin
    calc_s = alu_s;
    if (mode == OP_MAC) begin
      calc_s = {acc_next_s, 1'b0, 1'b0, (acc_next_s == {WIDTH{1'b0}}), 1'b0};
    end else begin
      calc_s = alu_s;
    end
  end
`else
  logic unused_acc_clr_s;
  assign unused_acc_clr_s = acc_clr;

  // Without the accumulator, the plain ALU result goes to stage 1 unchanged.
  always_comb begin
    calc_s = alu_s;
  end
`endif

  // Pipeline shift. Valid bits always advance, so bubbles stay in their slots.
  // Data advances only behind a valid item, so the output keeps its last
  // real value while a bubble is presented.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_r <= {STAGES{1'b0}};
      for (int i = 0; i < STAGES; i++) begin
        data_r[i] <= {DW{1'b0}};
      end
    end else if (advance_s) begin
      vld_r[0] <= valid_i;
      if (valid_i) begin
        data_r[0] <= calc_s;
      end
      for (int i = 1; i < STAGES; i++) begin
        vld_r[i] <= vld_r[i-1];
        if (vld_r[i-1]) begin
          data_r[i] <= data_r[i-1];
        end
      end
    end
  end

  assign valid_o = vld_r[STAGES-1];
  assign result  = data_r[STAGES-1][DW-1:4];
  assign carry   = data_r[STAGES-1][3];
  assign ovf     = data_r[STAGES-1][2];
  assign zero    = data_r[STAGES-1][1];
  assign err     = data_r[STAGES-1][0];

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed and random checks of alu_pipe with WIDTH=8, STAGES=2.
// The reference model keeps a queue of STAGES slots whose head is the output.
// It computes each result from the operation rules using integer arithmetic.
module tb_alu_pipe;
  localparam int W  = 8;
  localparam int ST = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] val1;
  logic [W-1:0] val2;
  logic [2:0]   mode;
  logic         valid_i;
  logic         ready_o;
  logic         acc_clr;
  logic [W-1:0] result;
  logic         carry;
  logic         ovf;
  logic         zero;
  logic         err;
  logic         valid_o;
  logic         ready_i;

  alu_pipe #(.WIDTH(W), .STAGES(ST)) dut (
    .clk(clk), .rst(rst), .val1(val1), .val2(val2), .mode(mode),
    .valid_i(valid_i), .ready_o(ready_o), .acc_clr(acc_clr),
    .result(result), .carry(carry), .ovf(ovf), .zero(zero), .err(err),
    .valid_o(valid_o), .ready_i(ready_i)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    bit         v;
    logic [7:0] r;
    bit         c;
    bit         o;
    bit         z;
    bit         e;
  } slot_t;

  slot_t slots[$];
  slot_t shown;
  int    acc;
  int    n_checks = 0;
  int    n_fail   = 0;
  int    deliv    = 0;
  bit    last_acc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int sx(input int x);
    return (x >= 128) ? x - 256 : x;
  endfunction

  function automatic slot_t calc(input int m, input int a, input int b, input int acc_new);
    slot_t s;
    int    v;
    int    so;
    s    = '0;
    s.v  = 1'b1;
    v    = 0;
    so   = 0;
    case (m)
      0: begin
        v   = a + b;
        s.c = (v > 255);
        so  = sx(a) + sx(b);
        s.o = (so > 127) || (so < -128);
      end
      1: begin
        v   = a - b;
        s.c = (a < b);
        so  = sx(a) - sx(b);
        s.o = (so > 127) || (so < -128);
      end
      2: v = a & b;
      3: v = a | b;
      4: v = a ^ b;
      5: v = a << (b % 8);
      6: v = a * b;
`ifdef ALU_PIPE_MAC_EN
      7: v = acc_new;
`else
      7: begin v = 0; s.e = 1'b1; end
`endif
      default: begin v = 0; s.e = 1'b1; end
    endcase
    s.r = v[7:0];
    s.z = (s.r == 8'h00);
    return s;
  endfunction

  task automatic model_reset();
    slot_t b;
    b = '0;
    slots.delete();
    for (int i = 0; i < ST; i++) slots.push_back(b);
    shown = '0;
    acc   = 0;
  endtask

  // Run one clock cycle. Drive inputs at the falling edge and check the
  // outputs against the model. The model then moves on at the rising edge.
  task automatic step(input bit v, input int m, input int a, input int b,
                      input bit clr, input bit rdy);
    bit    exp_rdy;
    int    acc_new;
    slot_t ns;
    @(negedge clk);
    valid_i = v;
    mode    = m[2:0];
    val1    = a[7:0];
    val2    = b[7:0];
    acc_clr = clr;
    ready_i = rdy;
    #1;
    exp_rdy = rdy || !slots[0].v;
    check("ready_o", ready_o, exp_rdy);
    check("valid_o", valid_o, slots[0].v);
    check("result", result, shown.r);
    check("flags", {carry, ovf, zero, err}, {shown.c, shown.o, shown.z, shown.e});
    if (slots[0].v && rdy) deliv++;
    last_acc = v && exp_rdy;
    acc_new = ((clr ? 0 : acc) + a * b) & 255;
    ns = calc(m, a, b, acc_new);
    ns.v = v;
    @(posedge clk);
    if (last_acc) begin
`ifdef ALU_PIPE_MAC_EN
      if (m == 7) acc = acc_new;
      else if (clr) acc = 0;
`endif
    end
    if (exp_rdy) begin
      void'(slots.pop_front());
      slots.push_back(ns);
      if (slots[0].v) shown = slots[0];
    end
  endtask

  // Compare the outputs with constant values shortly after a rising edge.
  task automatic expect_out(input string tag, input logic [7:0] r, input logic [3:0] f);
    #2;
    check({tag, "_valid"}, valid_o, 1'b1);
    check({tag, "_result"}, result, r);
    check({tag, "_flags"}, {carry, ovf, zero, err}, f);
  endtask

  initial begin
    logic [7:0] held;
    int         issued;
    int         cyc;
    logic [7:0] mac_r [3];
    logic [3:0] mac_f;

    rst = 1'b1; valid_i = 1'b0; ready_i = 1'b1; acc_clr = 1'b0;
    val1 = 8'h00; val2 = 8'h00; mode = 3'b000;
    model_reset();
    #3;
    check("rst_valid_o", valid_o, 1'b0);
    check("rst_ready_o", ready_o, 1'b1);
    check("rst_result", result, 8'h00);
    check("rst_flags", {carry, ovf, zero, err}, 4'h0);
    @(posedge clk); @(posedge clk); @(negedge clk);
    rst = 1'b0;

    // ADD with carry appears two cycles after accept.
    step(1, 0, 8'hF0, 8'h20, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    expect_out("add_carry", 8'h10, 4'b1000);
    // Signed overflow.
    step(1, 0, 8'h7F, 8'h01, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    expect_out("add_ovf", 8'h80, 4'b0100);
    // SUB giving zero, then SUB with a borrow.
    step(1, 1, 8'h05, 8'h05, 0, 1);
    step(1, 1, 8'h03, 8'h05, 0, 1);
    expect_out("sub_zero", 8'h00, 4'b0010);
    step(0, 0, 0, 0, 0, 1);
    expect_out("sub_borrow", 8'hFE, 4'b1000);
    step(0, 0, 0, 0, 0, 1);

    // Backpressure: five ADDs with ready_i low during cycles 3..6.
    deliv = 0; issued = 0; cyc = 0;
    while (issued < 5 && cyc < 40) begin
      step(1, 0, 8'h10 * issued + 1, 8'h03, 0, !(cyc >= 3 && cyc <= 6));
      if (cyc == 3) held = result;
      if (cyc >= 4 && cyc <= 6) check("stall_stable", result, held);
      if (cyc >= 3 && cyc <= 6) check("stall_ready_low", ready_o, 1'b0);
      if (last_acc) issued++;
      cyc++;
    end
    check("bp_issued", issued, 5);
    for (int i = 0; i < ST + 1; i++) step(0, 0, 0, 0, 0, 1);
    check("bp_delivered", deliv, 5);

    // MAC sequence. Without the accumulator, each item is an illegal op.
`ifdef ALU_PIPE_MAC_EN
    mac_r[0] = 8'h0C; mac_r[1] = 8'h16; mac_r[2] = 8'h16; mac_f = 4'b0000;
`else
    mac_r[0] = 8'h00; mac_r[1] = 8'h00; mac_r[2] = 8'h00; mac_f = 4'b0011;
`endif
    step(1, 7, 3, 4, 1, 1);
    step(1, 7, 2, 5, 0, 1);
    expect_out("mac0", mac_r[0], mac_f);
    step(1, 7, 8'h10, 8'h10, 0, 1);
    expect_out("mac1", mac_r[1], mac_f);
    step(0, 0, 0, 0, 0, 1);
    expect_out("mac2", mac_r[2], mac_f);
    step(0, 0, 0, 0, 0, 1);

    // Reset with two items in flight.
    step(1, 0, 1, 2, 0, 1);
    step(1, 0, 3, 4, 0, 1);
    #2;
    rst = 1'b1; valid_i = 1'b0;
    #1;
    check("midrst_valid_o", valid_o, 1'b0);
    check("midrst_result", result, 8'h00);
    model_reset();
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    // A MAC without acc_clr shows that the accumulator restarted from 0.
    step(1, 7, 2, 3, 0, 1);
    step(0, 0, 0, 0, 0, 1);
`ifdef ALU_PIPE_MAC_EN
    expect_out("post_rst", 8'h06, 4'b0000);
`else
    expect_out("post_rst", 8'h00, 4'b0011);
`endif

    // Random traffic with random backpressure, checked against the model.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 255),
           $urandom_range(0, 255), $urandom_range(0, 5) == 0, $urandom_range(0, 3) != 0);
    end
    for (int i = 0; i < ST + 1; i++) step(0, 0, 0, 0, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
